// File: rtl/rv32i_types.sv
// Shared rename-stage types: physical register sizing and free-list helpers.
package rv32i_types;

  localparam int NUM_REGS = 64;
  localparam int NUM_ARCH = 32;
  localparam int CAP      = NUM_REGS - NUM_ARCH;
  localparam int PW       = $clog2(NUM_REGS);
  localparam int HW       = (CAP > 1) ? $clog2(CAP) : 1;
  localparam int CW       = $clog2(CAP + 1);

  typedef logic [PW-1:0] phys_reg_t;
  typedef logic [HW-1:0] fl_ptr_t;
  typedef logic [CW-1:0] fl_count_t;

  // Advance a free-list pointer, wrapping modulo CAP (CAP need not be a power of two).
  function automatic fl_ptr_t ptr_inc(input fl_ptr_t p);
    if (p == fl_ptr_t'(CAP - 1)) begin
      return '0;
    end
    return p + fl_ptr_t'(1);
  endfunction

endpackage

// File: rtl/phys_free_list.sv
// Circular free list of physical register indices for the rename stage.
// Commit enqueues freed registers at the tail, rename dequeues at the head,
// and a flush restores the head to the tail so every in-flight allocation
// returns in one cycle.
// Optional feature: define FREE_LIST_BYPASS_EN to let a register freed into
// an empty list be handed straight to rename in the same cycle.
module phys_free_list
  import rv32i_types::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            reg_freed,
  input  phys_reg_t       liberated_phys_reg,
  input  logic            alloc_req,
  input  logic            flush,
  output logic            free_valid,
  output phys_reg_t       free_phys_reg,
  output logic [CW-1:0]   free_count,
  output logic            full
);

  phys_reg_t entries_reg [CAP];
  fl_ptr_t   head_reg, head_next;
  fl_ptr_t   tail_reg, tail_next;
  fl_count_t count_reg, count_next;

  logic count_zero;
  logic list_full;
  logic bypass_hit;
  logic bypass_take;
  logic do_enq;
  logic do_deq;

  assign count_zero = (count_reg == '0);
  assign list_full  = (count_reg == fl_count_t'(CAP));

`ifdef FREE_LIST_BYPASS_EN
  assign bypass_hit = count_zero && reg_freed;
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed register consumed in its freeing cycle never touches the array.
  assign bypass_take = bypass_hit && alloc_req && !flush;

  // Head-of-list view for rename; bypass forwards the freed index when empty.
  always_comb begin
    free_valid    = !count_zero || bypass_hit;
    free_phys_reg = bypass_hit ? liberated_phys_reg : entries_reg[head_reg];
  end

  assign free_count = count_reg;
  assign full       = list_full;

  // Next pointers and count; commit is older than a flush, so enqueue lands first.
  always_comb begin
    do_enq     = reg_freed && !list_full && !bypass_take;
    do_deq     = alloc_req && !count_zero && !flush;
    tail_next  = do_enq ? ptr_inc(tail_reg) : tail_reg;
    head_next  = head_reg;
    count_next = count_reg;
    if (flush) begin
      head_next  = tail_next;
      count_next = fl_count_t'(CAP);
    end else begin
      if (do_deq) begin
        head_next = ptr_inc(head_reg);
      end
      case ({do_enq, do_deq})
        2'b10:   count_next = count_reg + fl_count_t'(1);
        2'b01:   count_next = count_reg - fl_count_t'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // Pointer and count state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= fl_count_t'(CAP);
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Entry storage; reset holds every non-architectural register in order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CAP; i++) begin
        entries_reg[i] <= phys_reg_t'(NUM_ARCH + i);
      end
    end else if (do_enq) begin
      entries_reg[tail_reg] <= liberated_phys_reg;
    end
  end

`ifndef SYNTHESIS
  // Freeing into a full list means a register was freed twice or never allocated.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(reg_freed && list_full))
        else $warning("phys_free_list: enqueue of p%0d while list is full", liberated_phys_reg);
    end
  end
`endif

endmodule

// File: tb/tb_phys_free_list.sv
// Directed testbench for phys_free_list with hand-computed expectations.
module tb_phys_free_list;
  import rv32i_types::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          reg_freed;
  phys_reg_t     liberated_phys_reg;
  logic          alloc_req;
  logic          flush;
  logic          free_valid;
  phys_reg_t     free_phys_reg;
  logic [CW-1:0] free_count;
  logic          full;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  phys_free_list dut (
    .clk                (clk),
    .rst                (rst),
    .reg_freed          (reg_freed),
    .liberated_phys_reg (liberated_phys_reg),
    .alloc_req          (alloc_req),
    .flush              (flush),
    .free_valid         (free_valid),
    .free_phys_reg      (free_phys_reg),
    .free_count         (free_count),
    .full               (full)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    alloc_req          = 1'b0;
    reg_freed          = 1'b0;
    flush              = 1'b0;
    liberated_phys_reg = '0;
  endtask

  // One clock transaction: drive, report, clock, then return inputs to idle.
  task automatic cycle(input logic a, input logic f, input int lib, input logic fl);
    alloc_req          = a;
    reg_freed          = f;
    liberated_phys_reg = phys_reg_t'(lib);
    flush              = fl;
    #1;
    $display("txn alloc=%0b free=%0b(p%0d) flush=%0b | valid=%0b reg=p%0d count=%0d full=%0b",
             a, f, lib, fl, free_valid, free_phys_reg, free_count, full);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset contents
    check_eq("rst_valid", free_valid, 1);
    check_eq("rst_reg", free_phys_reg, 32);
    check_eq("rst_count", free_count, 32);
    check_eq("rst_full", full, 1);

    // Drain all 32 entries in order, then an ignored extra request
    for (int i = 0; i < 32; i++) begin
      check_eq("drain_valid", free_valid, 1);
      check_eq("drain_reg", free_phys_reg, 32 + i);
      cycle(1, 0, 0, 0);
    end
    check_eq("empty_valid", free_valid, 0);
    check_eq("empty_count", free_count, 0);
    check_eq("empty_full", full, 0);
    cycle(1, 0, 0, 0);
    check_eq("ignored_valid", free_valid, 0);
    check_eq("ignored_count", free_count, 0);

    // Frees land behind the remaining reset entries
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    cycle(0, 1, 5, 0);
    cycle(0, 1, 7, 0);
    check_eq("free2_count", free_count, 31);
    for (int i = 35; i < 64; i++) begin
      check_eq("tail_order_reg", free_phys_reg, i);
      cycle(1, 0, 0, 0);
    end
    check_eq("freed_first", free_phys_reg, 5);
    cycle(1, 0, 0, 0);
    check_eq("freed_second", free_phys_reg, 7);
    cycle(1, 0, 0, 0);
    check_eq("freed_drained_valid", free_valid, 0);

    // Simultaneous enqueue and dequeue keeps the count
    do_reset();
    cycle(1, 0, 0, 0);
    check_eq("simul_pre_count", free_count, 31);
    check_eq("simul_pre_reg", free_phys_reg, 33);
    cycle(1, 1, 10, 0);
    check_eq("simul_count", free_count, 31);
    check_eq("simul_reg", free_phys_reg, 34);

    // Flush restores the head to the tail; same-cycle alloc is dropped
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    check_eq("preflush_count", free_count, 29);
    cycle(1, 0, 0, 1);
    check_eq("flush_count", free_count, 32);
    check_eq("flush_full", full, 1);
    for (int k = 0; k < 32; k++) begin
      check_eq("flush_order_reg", free_phys_reg, (k < 31) ? 33 + k : 1);
      cycle(1, 0, 0, 0);
    end
    check_eq("flush_drained_valid", free_valid, 0);

    // Flush with same-cycle enqueue uses the post-enqueue tail
    do_reset();
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 4, 1);
    check_eq("flush_enq_count", free_count, 32);
    check_eq("flush_enq_reg", free_phys_reg, 33);
    for (int i = 0; i < 31; i++) cycle(1, 0, 0, 0);
    check_eq("flush_enq_wrap_reg", free_phys_reg, 4);

    // Free into an empty list with a same-cycle request
    do_reset();
    for (int i = 0; i < 32; i++) cycle(1, 0, 0, 0);
    alloc_req          = 1'b1;
    reg_freed          = 1'b1;
    liberated_phys_reg = phys_reg_t'(9);
    #1;
`ifdef FREE_LIST_BYPASS_EN
    check_eq("bypass_valid", free_valid, 1);
    check_eq("bypass_reg", free_phys_reg, 9);
    cycle(1, 1, 9, 0);
    check_eq("bypass_after_count", free_count, 0);
    check_eq("bypass_after_valid", free_valid, 0);
`else
    check_eq("nobypass_valid", free_valid, 0);
    cycle(1, 1, 9, 0);
    check_eq("nobypass_after_count", free_count, 1);
    check_eq("nobypass_after_valid", free_valid, 1);
    check_eq("nobypass_after_reg", free_phys_reg, 9);
`endif

    // Asynchronous reset mid-stream overrides flush, enqueue and alloc
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
    alloc_req          = 1'b1;
    reg_freed          = 1'b1;
    liberated_phys_reg = phys_reg_t'(3);
    flush              = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    check_eq("async_rst_valid", free_valid, 1);
    check_eq("async_rst_reg", free_phys_reg, 32);
    check_eq("async_rst_count", free_count, 32);
    check_eq("async_rst_full", full, 1);
    @(posedge clk);
    #1;
    check_eq("async_hold_count", free_count, 32);
    check_eq("async_hold_reg", free_phys_reg, 32);
    idle_inputs();
    rst = 1'b1;
    cycle(1, 0, 0, 0);
    check_eq("post_rst_reg", free_phys_reg, 33);

    // Enqueue on a full list leaves state untouched
    do_reset();
    cycle(0, 1, 2, 0);
    check_eq("full_enq_count", free_count, 32);
    check_eq("full_enq_full", full, 1);
    check_eq("full_enq_reg", free_phys_reg, 32);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 40, 0);
    for (int i = 0; i < 31; i++) cycle(1, 0, 0, 0);
    check_eq("full_enq_tail_reg", free_phys_reg, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
